// File: rtl/lpf_fir_core.sv
// rtl/lpf_fir_core.sv - fixed 5-tap binomial (1,4,6,4,1)/16 low-pass FIR core
//
// Purpose: one 16-bit signed sample in and one registered, rounded 16-bit
//          signed sample out on every enabled clock.
// Ports:
//   clk_i   sole clock, rising edge
//   rstn_i  synchronous reset, active HIGH despite the name; wins over en_i
//   en_i    sample enable; x_i accepted and y_o updated when high
//   x_i     input sample, two's-complement
//   y_o     filtered output sample, two's-complement, straight from a flop
module lpf_fir_core (
  input  logic        clk_i,
  input  logic        rstn_i,
  input  logic        en_i,
  input  logic [15:0] x_i,
  output logic [15:0] y_o
);

  // Delay line: d0 newest accepted sample, d3 oldest.
  logic signed [15:0] d0_q, d1_q, d2_q, d3_q;
  logic signed [15:0] d0_d, d1_d, d2_d, d3_d;
  logic signed [15:0] y_q, y_d;

  // 20-bit sign-extended operands; the full sum range is [-524288, +524272]
  // so 20 bits never overflow, including the +8 rounding offset.
  logic signed [19:0] x_ext, d0_ext, d1_ext, d2_ext, d3_ext;
  logic signed [19:0] acc;

  always_comb begin
    x_ext  = {{4{x_i[15]}}, x_i};
    d0_ext = {{4{d0_q[15]}}, d0_q};
    d1_ext = {{4{d1_q[15]}}, d1_q};
    d2_ext = {{4{d2_q[15]}}, d2_q};
    d3_ext = {{4{d3_q[15]}}, d3_q};
  end

  // Weights built from shifts: 4 = <<2, 6 = <<2 + <<1.
  always_comb begin
    acc = x_ext
        + (d0_ext <<< 2)
        + (d1_ext <<< 2) + (d1_ext <<< 1)
        + (d2_ext <<< 2)
        + d3_ext;
  end

  // Round half toward +infinity: add half an LSB of the /16 result, then
  // arithmetic shift. The result always fits in 16 bits, so truncate.
  always_comb begin
    d0_d = d0_q;
    d1_d = d1_q;
    d2_d = d2_q;
    d3_d = d3_q;
    y_d  = y_q;
    if (en_i) begin
      y_d  = 16'((acc + 20'sd8) >>> 4);
      d0_d = x_i;
      d1_d = d0_q;
      d2_d = d1_q;
      d3_d = d2_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rstn_i) begin
      d0_q <= '0;
      d1_q <= '0;
      d2_q <= '0;
      d3_q <= '0;
      y_q  <= '0;
    end else begin
      d0_q <= d0_d;
      d1_q <= d1_d;
      d2_q <= d2_d;
      d3_q <= d3_d;
      y_q  <= y_d;
    end
  end

  assign y_o = y_q;

endmodule

// File: tb/tb_lpf_fir_core.sv
// tb/tb_lpf_fir_core.sv - self-checking bench for lpf_fir_core
module tb_lpf_fir_core;

  logic        clk;
  logic        rst;
  logic        en;
  logic [15:0] x;
  logic [15:0] y;

  int checks;
  int failures;

  // Reference model: last four accepted samples (index 0 newest) and output.
  int m_hist[4];
  int m_y;

  lpf_fir_core dut (
    .clk_i  (clk),
    .rstn_i (rst),
    .en_i   (en),
    .x_i    (x),
    .y_o    (y)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int floor_div16(input int a);
    if (a >= 0) return a / 16;
    return -((-a + 15) / 16);
  endfunction

  function automatic int model_out(input int xs);
    int acc;
    acc = xs + 4 * m_hist[0] + 6 * m_hist[1] + 4 * m_hist[2] + m_hist[3];
    return floor_div16(acc + 8);
  endfunction

  // One clock: drive on the falling edge, sample 1 time unit after rising.
  task automatic apply(input logic r, input logic e, input logic [15:0] xv);
    int xs;
    @(negedge clk);
    rst = r;
    en  = e;
    x   = xv;
    @(posedge clk);
    #1;
    xs = int'($signed(xv));
    if (r) begin
      for (int i = 0; i < 4; i++) m_hist[i] = 0;
      m_y = 0;
    end else if (e) begin
      m_y = model_out(xs);
      for (int i = 3; i > 0; i--) m_hist[i] = m_hist[i-1];
      m_hist[0] = xs;
    end
  endtask

  task automatic test_reset;
    apply(1'b1, 1'($urandom), 16'($urandom));
    checks++;
    if (y !== 16'h0000) begin
      failures++;
      $display("FAIL reset_y actual=%h expected=0000", y);
    end
    apply(1'b0, 1'b1, 16'h0000);
    checks++;
    if (y !== 16'h0000) begin
      failures++;
      $display("FAIL reset_zero_in actual=%h expected=0000", y);
    end
  endtask

  task automatic test_impulse;
    int exp_tab[7] = '{256, 1024, 1536, 1024, 256, 0, 0};
    apply(1'b1, 1'b0, 16'h0000);
    for (int i = 0; i < 7; i++) begin
      apply(1'b0, 1'b1, (i == 0) ? 16'd4096 : 16'd0);
      checks++;
      if ($signed(y) != exp_tab[i] || y !== 16'(m_y)) begin
        failures++;
        $display("FAIL impulse[%0d] actual=%0d expected=%0d", i, $signed(y), exp_tab[i]);
      end
    end
  endtask

  task automatic test_step_pos;
    int exp_tab[7] = '{2048, 10240, 22527, 30719, 32767, 32767, 32767};
    apply(1'b1, 1'b0, 16'h0000);
    for (int i = 0; i < 7; i++) begin
      apply(1'b0, 1'b1, 16'h7FFF);
      checks++;
      if ($signed(y) != exp_tab[i] || y !== 16'(m_y)) begin
        failures++;
        $display("FAIL step_pos[%0d] actual=%0d expected=%0d", i, $signed(y), exp_tab[i]);
      end
    end
  endtask

  task automatic test_step_neg;
    apply(1'b1, 1'b0, 16'h0000);
    for (int i = 0; i < 8; i++) begin
      apply(1'b0, 1'b1, 16'h8000);
      checks++;
      if (y !== 16'(m_y) || (i == 0 && y !== 16'hF800) || (i >= 4 && y !== 16'h8000)) begin
        failures++;
        $display("FAIL step_neg[%0d] actual=%h model=%h", i, y, 16'(m_y));
      end
    end
  endtask

  task automatic test_enable_gating;
    int exp_tab[7] = '{256, 1024, 1536, 1024, 256, 0, 0};
    apply(1'b1, 1'b0, 16'h0000);
    apply(1'b0, 1'b1, 16'd4096);
    apply(1'b0, 1'b1, 16'd0);
    checks++;
    if ($signed(y) != exp_tab[1]) begin
      failures++;
      $display("FAIL gate_pre actual=%0d expected=%0d", $signed(y), exp_tab[1]);
    end
    for (int i = 0; i < 3; i++) begin
      apply(1'b0, 1'b0, 16'($urandom));
      checks++;
      if ($signed(y) != exp_tab[1]) begin
        failures++;
        $display("FAIL gate_hold[%0d] actual=%0d expected=%0d", i, $signed(y), exp_tab[1]);
      end
    end
    for (int i = 2; i < 7; i++) begin
      apply(1'b0, 1'b1, 16'd0);
      checks++;
      if ($signed(y) != exp_tab[i]) begin
        failures++;
        $display("FAIL gate_resume[%0d] actual=%0d expected=%0d", i, $signed(y), exp_tab[i]);
      end
    end
  endtask

  task automatic test_reset_mid;
    apply(1'b1, 1'b0, 16'h0000);
    for (int i = 0; i < 3; i++) apply(1'b0, 1'b1, 16'h7FFF);
    apply(1'b1, 1'b1, 16'h7FFF);
    checks++;
    if (y !== 16'h0000) begin
      failures++;
      $display("FAIL reset_mid actual=%h expected=0000", y);
    end
    apply(1'b0, 1'b1, 16'h7FFF);
    checks++;
    if ($signed(y) != 2048) begin
      failures++;
      $display("FAIL reset_mid_restart actual=%0d expected=2048", $signed(y));
    end
    apply(1'b0, 1'b1, 16'h7FFF);
    checks++;
    if ($signed(y) != 10240) begin
      failures++;
      $display("FAIL reset_mid_second actual=%0d expected=10240", $signed(y));
    end
  endtask

  task automatic test_random;
    logic        r;
    logic        e;
    logic [15:0] xv;
    apply(1'b1, 1'b0, 16'h0000);
    for (int i = 0; i < 400; i++) begin
      r = ($urandom_range(0, 59) == 0);
      e = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 7))
        0:       xv = 16'h7FFF;
        1:       xv = 16'h8000;
        default: xv = 16'($urandom);
      endcase
      apply(r, e, xv);
      checks++;
      if (y !== 16'(m_y)) begin
        failures++;
        $display("FAIL random[%0d] actual=%0d expected=%0d rst=%0b en=%0b x=%0d",
                 i, $signed(y), m_y, r, e, $signed(xv));
      end
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    en       = 1'b0;
    x        = 16'h0000;
    m_y      = 0;
    for (int i = 0; i < 4; i++) m_hist[i] = 0;
    test_reset;
    test_impulse;
    test_step_pos;
    test_step_neg;
    test_enable_gating;
    test_reset_mid;
    test_random;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
